// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone widths and arbiter state encoding for the round-robin arbiter.
package wb_arbiter_pkg;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester searching upward from last+1.
module rr_priority_picker #(
  parameter int N  = 2,
  parameter int LW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_gnt
);
  logic          w_found;
  logic [LW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // i runs 1..N so the last winner is checked last, giving it lowest priority
    for (int i = 1; i <= N; i++) begin
      w_idx = LW'((int'(i_last) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter with bus-timeout watchdog.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [ADR_W*NUM_MASTERS-1:0] m_adr_i,
  input  logic [DAT_W*NUM_MASTERS-1:0] m_dat_i,
  input  logic [SEL_W*NUM_MASTERS-1:0] m_sel_i,
  output logic [DAT_W-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0]       m_rty_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [ADR_W-1:0]             s_adr_o,
  output logic [DAT_W-1:0]             s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  input  logic [DAT_W-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_rty_i,
  output logic [NUM_MASTERS-1:0]       gnt_o
);
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_gnt, w_pick, w_gv;
  logic [LW-1:0]          r_last, w_pick_idx;
  logic [CW-1:0]          r_cnt;
  logic                   w_own_cyc, w_to, w_cyc, w_stb;

  rr_priority_picker #(.N(NUM_MASTERS), .LW(LW)) u_picker (
    .i_req  (m_cyc_i),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (w_pick[k]) w_pick_idx = LW'(k);
  end

  assign w_own_cyc = |(m_cyc_i & r_gnt);
  assign w_gv      = (r_state == ST_GRANTED) ? r_gnt : '0;
  // Counter reads TO_MAX in the cycle after the last stalled cycle: that cycle is the abort.
  assign w_to      = (TIMEOUT_CYCLES != 0) && (r_state == ST_GRANTED) && (r_cnt == TO_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|m_cyc_i)   w_state_nxt = ST_GRANTED;
      ST_GRANTED: if (!w_own_cyc) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt  <= '0;
      r_last <= LW'(NUM_MASTERS - 1);
    end else if (r_state == ST_IDLE && |m_cyc_i) begin
      r_gnt  <= w_pick;
      r_last <= w_pick_idx;
    end else if (r_state == ST_GRANTED && !w_own_cyc) begin
      r_gnt  <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || TIMEOUT_CYCLES == 0 || r_state != ST_GRANTED || !s_stb_o ||
        s_ack_i || s_err_i || s_rty_i)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (w_gv[k]) begin
        w_cyc   = m_cyc_i[k];
        w_stb   = m_stb_i[k];
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[k*ADR_W +: ADR_W];
        s_dat_o = m_dat_i[k*DAT_W +: DAT_W];
        s_sel_o = m_sel_i[k*SEL_W +: SEL_W];
      end
    end
  end

  assign s_cyc_o = w_cyc & ~w_to;
  assign s_stb_o = w_stb & ~w_to;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = w_gv & {NUM_MASTERS{s_ack_i & ~w_to}};
  assign m_rty_o = w_gv & {NUM_MASTERS{s_rty_i & ~w_to}};
  assign m_err_o = w_gv & {NUM_MASTERS{s_err_i | w_to}};
  assign gnt_o   = r_gnt;
endmodule
